// File: rtl/rxdata_word_aligner_pkg.sv
// Shared types and helpers for the RX word aligner.
// The default word width follows the serializer stage count.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

package rx_pkg;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} rx_state_e;

    localparam int DEF_WIDTH = 2 ** `SERDES_STAGES;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // WIDTH-1 ones with a zero MSB: the wire sees ones first, then the zero.
    function automatic logic [63:0] default_train_word(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction
endpackage

// File: rtl/rxdata_word_aligner_if.sv
// Bit-stream input and aligned-word output bundle of the RX word aligner.
interface rxdata_word_aligner_if
    import rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             din;
    logic             bit_valid;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             locked;

    modport master (output din, bit_valid, en, input dout, dout_valid, locked);
    modport slave  (input din, bit_valid, en, output dout, dout_valid, locked);
endinterface

// File: rtl/rxdata_word_aligner_shift_cnt.sv
// LSB-first deserializing shift register and modulo-WIDTH bit counter.
// Flags the bit that completes a word; the counter can be re-phased by i_cnt_clr.
module rx_shift_cnt
    import rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_din,
    input  logic             i_bit_valid,
    input  logic             i_cnt_clr,
    output logic [WIDTH-1:0] o_sr_next,
    output logic             o_boundary
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;

    if (WIDTH == 1) begin : g_narrow
        assign o_sr_next = i_din;
    end else begin : g_wide
        assign o_sr_next = {i_din, r_sr[WIDTH-1:1]};
    end

    assign o_boundary = i_bit_valid && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_bit_valid) begin
            r_sr <= o_sr_next;
            // A clear re-phases the counter so the next WIDTH bits form a word.
            if (i_cnt_clr || r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rxdata_word_aligner.sv
// Serial-to-parallel word aligner: hunts for the training word, confirms it
// over consecutive words, then emits every aligned word with a one-cycle pulse.
module rxdata_word_aligner
    import rx_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(default_train_word(WIDTH)),
    parameter int               LOCK_COUNT = 4
) (
    input logic                  clk,
    input logic                  rst,
    rxdata_word_aligner_if.slave bus
);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    rx_state_e        r_state;
    rx_state_e        w_state_next;
    logic [3:0]       r_mcnt;
    logic [3:0]       w_mcnt_next;
    logic [3:0]       w_mcnt_inc;
    logic             w_cnt_clr;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_boundary;
    logic             w_match;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_next;
    logic             r_dout_valid;
    logic             w_dout_valid_next;
    logic             r_locked;

    rx_shift_cnt #(.WIDTH(WIDTH)) u_shift_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_din       (bus.din),
        .i_bit_valid (bus.bit_valid),
        .i_cnt_clr   (w_cnt_clr),
        .o_sr_next   (w_sr_next),
        .o_boundary  (w_boundary)
    );

    assign w_match    = (w_sr_next == TRAIN_WORD);
    assign w_mcnt_inc = r_mcnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_mcnt  <= w_mcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mcnt_next  = r_mcnt;
        w_cnt_clr    = 1'b0;
        if (!bus.en) begin
            w_state_next = HUNT;
            w_mcnt_next  = '0;
        end else begin
            case (r_state)
                HUNT: begin
                    // Any bit position may be the boundary while hunting.
                    if (bus.bit_valid && w_match) begin
                        w_cnt_clr    = 1'b1;
                        w_mcnt_next  = 4'd1;
                        w_state_next = (LOCK_CNT == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_boundary) begin
                        if (w_match) begin
                            w_mcnt_next = w_mcnt_inc;
                            if (w_mcnt_inc == LOCK_CNT) begin
                                w_state_next = LOCKED;
                            end
                        end else begin
                            w_mcnt_next  = '0;
                            w_state_next = HUNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_dout_next       = r_dout;
        w_dout_valid_next = 1'b0;
        if (bus.en && r_state == LOCKED && w_boundary) begin
            w_dout_next       = w_sr_next;
            w_dout_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_dout       <= w_dout_next;
            r_dout_valid <= w_dout_valid_next;
            r_locked     <= (w_state_next == LOCKED);
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.locked     = r_locked;
endmodule

// File: tb/tb_rxdata_word_aligner.sv
// Self-checking bench for rxdata_word_aligner: table-driven lock/data runs,
// a scoreboard of expected words, and hand-written reset/enable corner cases.
module tb_rxdata_word_aligner;
    import rx_pkg::*;

    localparam int         W     = 4;
    localparam logic [3:0] TRAIN = 4'b0111;

    typedef struct {
        logic [3:0] word;
        bit         emit;
        bit         lock_chk;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rxdata_word_aligner_if #(.WIDTH(W)) bus ();

    rxdata_word_aligner #(
        .WIDTH      (W),
        .TRAIN_WORD (TRAIN),
        .LOCK_COUNT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         epoch  = 0;
    int         gphase = 0;
    bit         gap_mode = 1'b0;
    logic [3:0] exp_q[$];
    vec_t       tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compares every dout_valid pulse against the queue.
    task automatic monitor();
        int   cyc = 0;
        int   last_cyc = 0;
        int   last_epoch = -1;
        logic prev_bv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && bus.dout_valid === 1'b1) begin
                pulses++;
                chk("pulse_on_boundary", {31'd0, prev_bv}, 1);
                chk("pulse_expected", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    chk("dout_word", {28'd0, bus.dout}, {28'd0, e});
                    $display("pulse: dout=%h expected=%h cycle=%0d", bus.dout, e, cyc);
                end
                if (last_epoch == epoch) begin
                    if (gap_mode) chk("no_back_to_back", {31'd0, (cyc - last_cyc) > 1}, 1);
                    else          chk("pulse_spacing", cyc - last_cyc, W);
                end
                last_epoch = epoch;
                last_cyc   = cyc;
            end
            prev_bv = bus.bit_valid;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (gap_mode && (gphase % 3 == 2)) begin
            bus.bit_valid = 1'b0;
            tick();
            gphase++;
        end
        bus.din       = b;
        bus.bit_valid = 1'b1;
        tick();
        gphase++;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int b = 0; b < W; b++) send_bit(w[b]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        epoch++;
        gphase = 0;
    endtask

    task automatic drain();
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        epoch++;
    endtask

    task automatic load_tbl(input logic [3:0] d0, input logic [3:0] d1);
        tbl.delete();
        tbl.push_back('{TRAIN, 1'b0, 1'b0});
        tbl.push_back('{TRAIN, 1'b0, 1'b0});
        tbl.push_back('{TRAIN, 1'b0, 1'b0});
        tbl.push_back('{TRAIN, 1'b0, 1'b1});
        tbl.push_back('{d0, 1'b1, 1'b0});
        tbl.push_back('{d1, 1'b1, 1'b0});
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            if (tbl[i].emit) exp_q.push_back(tbl[i].word);
            if (tbl[i].lock_chk) begin
                for (int b = 0; b < W - 1; b++) send_bit(tbl[i].word[b]);
                chk("locked_before_last_train_bit", {31'd0, bus.locked}, 0);
                send_bit(tbl[i].word[W-1]);
                chk("locked_after_last_train_bit", {31'd0, bus.locked}, 1);
            end else begin
                send_word(tbl[i].word);
            end
        end
    endtask

    initial begin
        int snap;
        bus.din       = 1'b0;
        bus.bit_valid = 1'b0;
        bus.en        = 1'b1;
        fork
            monitor();
        join_none

        // 1: reset held with random stimulus
        for (int c = 0; c < 3; c++) begin
            bus.din       = 1'($urandom);
            bus.bit_valid = 1'($urandom);
            tick();
            chk("rst_dout", {28'd0, bus.dout}, 0);
            chk("rst_dout_valid", {31'd0, bus.dout_valid}, 0);
            chk("rst_locked", {31'd0, bus.locked}, 0);
        end
        bus.bit_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 2: lock then two data words
        load_tbl(4'hA, 4'h5);
        send_bit(1'b0);
        send_bit(1'b1);
        run_tbl();
        drain();

        // 3: verify failure after two training words
        do_reset();
        send_word(TRAIN);
        send_word(TRAIN);
        send_word(4'h0);
        chk("verify_fail_unlocked", {31'd0, bus.locked}, 0);
        load_tbl(4'h9, 4'h6);
        run_tbl();
        drain();

        // 4: gapped input
        do_reset();
        gap_mode = 1'b1;
        load_tbl(4'hA, 4'h5);
        send_bit(1'b0);
        send_bit(1'b1);
        run_tbl();
        drain();
        gap_mode = 1'b0;

        // 5: enable drop mid-word
        do_reset();
        load_tbl(4'hA, 4'h3);
        run_tbl();
        drain();
        send_bit(1'b0);
        send_bit(1'b0);
        snap = pulses;
        bus.en = 1'b0;
        send_bit(1'b0);
        chk("en_drop_locked", {31'd0, bus.locked}, 0);
        send_bit(1'b0);
        bus.en = 1'b1;
        for (int b = 0; b < 8; b++) send_bit(1'b0);
        tick();
        chk("en_drop_no_pulse", pulses, snap);
        chk("en_drop_still_unlocked", {31'd0, bus.locked}, 0);
        epoch++;
        load_tbl(4'h3, 4'hC);
        run_tbl();
        drain();

        // 6: reset mid-word while locked
        do_reset();
        load_tbl(4'hA, 4'hD);
        run_tbl();
        drain();
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_dout", {28'd0, bus.dout}, 0);
        chk("midrst_dout_valid", {31'd0, bus.dout_valid}, 0);
        chk("midrst_locked", {31'd0, bus.locked}, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        epoch++;
        snap = pulses;
        for (int k = 0; k < 3; k++) send_word(4'hA);
        tick();
        chk("midrst_no_pulse", pulses, snap);
        load_tbl(4'hC, 4'h2);
        run_tbl();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
